// File: rtl/if_id_buffer_if.sv
// Handshake bundle between the fetch stage, the IF/ID buffer and the decode stage.
interface if_id_buffer_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [5:0]  out_op;
    logic [5:0]  out_func;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_sa;
    logic [1:0]  count;

    // Fetch/decode side: drives requests and consumes the buffer outputs.
    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_op, out_func,
               out_rs, out_rt, out_rd, out_sa, count
    );

    // Buffer side.
    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_op, out_func,
               out_rs, out_rt, out_rd, out_sa, count
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry in-order FIFO between instruction fetch and decode.
// No bypass: a pushed instruction is visible one cycle later. Outputs are
// forced to zero while the buffer is empty so decoders see a clean NOP.
module if_id_buffer (
    input logic           clk,
    input logic           resetn,
    if_id_buffer_if.slave bus
);

    logic [31:0] pc_q   [2];
    logic [31:0] inst_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count_q;

    logic        push;
    logic        pop;
    logic        not_empty;
    logic [31:0] head_pc;
    logic [31:0] head_inst;

    assign not_empty     = (count_q != 2'd0);
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = not_empty;
    assign bus.count     = count_q;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = not_empty && bus.out_ready;

    // Pointer, occupancy and storage update; flush wins over push/pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count_q   <= 2'd0;
            pc_q[0]   <= 32'd0;
            pc_q[1]   <= 32'd0;
            inst_q[0] <= 32'd0;
            inst_q[1] <= 32'd0;
        end else if (bus.flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]   <= bus.in_pc;
                inst_q[wr_ptr] <= bus.in_inst;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head entry, zeroed while empty; decode fields are plain slices.
    always_comb begin
        head_pc   = 32'd0;
        head_inst = 32'd0;
        if (not_empty) begin
            head_pc   = pc_q[rd_ptr];
            head_inst = inst_q[rd_ptr];
        end
    end

    assign bus.out_pc   = head_pc;
    assign bus.out_inst = head_inst;
    assign bus.out_op   = head_inst[31:26];
    assign bus.out_rs   = head_inst[25:21];
    assign bus.out_rt   = head_inst[20:16];
    assign bus.out_rd   = head_inst[15:11];
    assign bus.out_sa   = head_inst[10:6];
    assign bus.out_func = head_inst[5:0];

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port flush, input, 1, synchronous discard of all buffered instructions (branch/exception redirect).
REQ-004 SHALL have port in_valid, input, 1, fetch stage presents an instruction.
REQ-005 SHALL have port in_ready, output, 1, buffer can accept an instruction this cycle.
REQ-006 SHALL have port in_pc, input, 32, PC of the presented instruction.
REQ-007 SHALL have port in_inst, input, 32, presented instruction word.
REQ-008 SHALL have port out_valid, output, 1, head entry valid for the decode stage.
REQ-009 SHALL have port out_ready, input, 1, decode stage consumes the head entry this cycle.
REQ-010 SHALL have port out_pc, output, 32, PC of the head entry.
REQ-011 SHALL have port out_inst, output, 32, instruction word of the head entry.
REQ-012 SHALL have port out_op, output, 6, out_inst[31:26], feeding the opcode 6-to-64 decoder.
REQ-013 SHALL have port out_func, output, 6, out_inst[5:0], feeding the function 6-to-64 decoder.
REQ-014 SHALL have ports out_rs, out_rt, out_rd, out_sa, output, 5 each, out_inst[25:21], [20:16], [15:11], [10:6].
REQ-015 SHALL have port count, output, 2, number of valid entries (0..2).

Function
REQ-016 SHALL be a 2-entry in-order FIFO of {pc, inst}, with a 1-bit read pointer, a 1-bit write pointer, and a 2-bit count.
REQ-017 SHALL accept (push) when in_valid && in_ready, and SHALL pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count != 2), combinational from count only, with no dependence on out_ready.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL drive out_pc, out_inst and all field outputs from the head entry when out_valid is 1, and SHALL drive them to 0 when out_valid is 0.
REQ-021 SHALL provide no bypass: an instruction pushed in cycle N appears on out_* first in cycle N+1 (latency 1).
REQ-022 On simultaneous push and pop at count 1, count SHALL remain 1, the new entry SHALL become head in the next cycle, and no entry SHALL be lost.
REQ-023 At count 2, in_ready SHALL be 0, so no push occurs; a pop SHALL reduce count to 1.
REQ-024 At count 0, out_ready SHALL be ignored, and a pop SHALL NOT occur.
REQ-025 Pointers SHALL wrap from 1 to 0 with no bubble.
REQ-026 Entries SHALL hold their value while not popped, whatever the in_* activity.
REQ-027 When flush is 1, the next edge SHALL set count and both pointers to 0, and any push or pop in the same cycle SHALL be discarded; flush SHALL have priority over push and pop.
REQ-028 The buffer SHALL NOT alter instruction bits; fields are pure slices of the stored word.

Reset
REQ-029 While resetn is 0, count, both pointers and all entry storage SHALL be 0 immediately (asynchronously), giving out_valid=0, out_pc=0, out_inst=0, all fields 0, and in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first push after reset deassertion SHALL behave as a push into an empty buffer.

Verification
REQ-031 Scenario 1: push pc=0xBFC00000, inst=0x24080005 at cycle 0 with out_ready=0 -> cycle 1: out_valid=1, out_op=0x09, out_rt=8, count=1.
REQ-032 Scenario 2: push 3 consecutive instructions with out_ready=0 -> count=2 and in_ready=0 after 2 pushes; the third instruction is held off; after 2 pops, outputs appear in push order.
REQ-033 Scenario 3: at count=1, push and pop in the same cycle for 10 cycles -> count stays 1, and each out_pc equals the PC pushed one cycle earlier.
REQ-034 Scenario 4: at count=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle: count=0, out_valid=0, out_inst=0.
REQ-035 Scenario 5: pull resetn low mid-cycle at count=2 -> outputs are 0 and count=0 before the next clock edge.
REQ-036 Scenario 6: push inst=0x00851020 -> out_op=0, out_func=0x20, out_rs=4, out_rt=5, out_rd=2, out_sa=0.
